// File: rtl/controlador_barrido_display_pkg.sv
// Shared constants for the 4-digit multiplexed readout: anode patterns,
// mode encodings and digit indices.
package pkg_display;

    localparam logic [3:0] ANODOS_APAGADOS = 4'b1111;

    localparam logic MODO_CORRIENTE  = 1'b0;
    localparam logic MODO_FRECUENCIA = 1'b1;

    typedef enum logic [1:0] {
        UNIDADES = 2'd0,
        DECENAS  = 2'd1,
        CENTENAS = 2'd2,
        MILLARES = 2'd3
    } digito_t;

    // Active-low one-hot anode for the given digit index.
    function automatic logic [3:0] anodo_activo(input logic [1:0] sel);
        logic [3:0] uno;
        uno = 4'b0001;
        return ~(uno << sel);
    endfunction

endpackage

// File: rtl/controlador_barrido_display_if.sv
// Scan-control bundle between the display controller (master) and the
// readout hardware/host side (slave).
interface controlador_barrido_display_if;
    import pkg_display::*;

    logic       habilitar;
    logic       modo_auto;
    logic       modo_manual;
    logic [1:0] seleccion;
    logic [3:0] anodos;
    logic       modo;
    logic       fin_cuadro;

    modport master (
        input  habilitar, modo_auto, modo_manual,
        output seleccion, anodos, modo, fin_cuadro
    );

    modport slave (
        output habilitar, modo_auto, modo_manual,
        input  seleccion, anodos, modo, fin_cuadro
    );

endinterface

// File: rtl/controlador_barrido_display_contador.sv
// Mod-N up-counter with enable, synchronous reset, terminal-count flag and
// its next-state value exposed so callers can register decoded outputs.
module contador_modulo #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] valor_o,
    output logic [W-1:0] valor_d_o,
    output logic         tc_o
);

    localparam logic [W-1:0] ULTIMO = W'(N - 1);

    logic [W-1:0] valor_q, valor_d;

    assign tc_o = (valor_q == ULTIMO);

    always_comb begin
        valor_d = valor_q;
        if (en_i) begin
            valor_d = tc_o ? '0 : valor_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_o   = valor_q;
    assign valor_d_o = valor_d;

endmodule

// File: rtl/controlador_barrido_display.sv
// Digit-scan controller for the 4-digit 7-segment readout: dead-time blanked
// anode multiplexing plus frame-aligned current/frequency mode selection.
module controlador_barrido_display
    import pkg_display::*;
#(
    parameter int DIV_DIGITO  = 50000,
    parameter int DEAD        = 500,
    parameter int FRAMES_MODO = 250
) (
    input  logic                          clk,
    input  logic                          reset,
    controlador_barrido_display_if.master bus
);

    localparam int CW = (DIV_DIGITO > 1) ? $clog2(DIV_DIGITO) : 1;
    localparam int FW = (FRAMES_MODO > 1) ? $clog2(FRAMES_MODO) : 1;
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_tc;
    logic [FW-1:0] fc_q, fc_d;
    logic          fc_tc;
    logic          fc_unused;

    logic [1:0] sel_q, sel_d;
    logic       modo_q, modo_d;
    logic [3:0] anodos_q, anodos_d;
    logic       fin_q, fin_d;

    logic fin_slot;
    logic fin_marco;

    assign fin_slot  = bus.habilitar && cnt_tc;
    assign fin_marco = fin_slot && (sel_q == MILLARES);

    contador_modulo #(
        .N (DIV_DIGITO),
        .W (CW)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .en_i      (bus.habilitar),
        .valor_o   (cnt_q),
        .valor_d_o (cnt_d),
        .tc_o      (cnt_tc)
    );

    // In manual mode fc is cleared at every frame end so auto restarts from 0.
    contador_modulo #(
        .N (FRAMES_MODO),
        .W (FW)
    ) u_fc (
        .clk       (clk),
        .reset     (reset || (fin_marco && !bus.modo_auto)),
        .en_i      (fin_marco && bus.modo_auto),
        .valor_o   (fc_q),
        .valor_d_o (fc_d),
        .tc_o      (fc_tc)
    );

    assign fc_unused = ^{fc_q, fc_d};

    always_comb begin
        sel_d = sel_q;
        if (fin_slot) begin
            sel_d = sel_q + 2'd1;
        end
    end

    always_comb begin
        modo_d = modo_q;
        if (fin_marco) begin
            if (bus.modo_auto) begin
                if (fc_tc) begin
                    modo_d = ~modo_q;
                end
            end else begin
                modo_d = bus.modo_manual;
            end
        end
    end

    // Output flops are fed from next-state so they line up with cnt/seleccion.
    always_comb begin
        anodos_d = ANODOS_APAGADOS;
        if (bus.habilitar && (cnt_d >= DEAD_C)) begin
            anodos_d = anodo_activo(sel_d);
        end
        fin_d = fin_marco;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q    <= UNIDADES;
            modo_q   <= MODO_CORRIENTE;
            anodos_q <= ANODOS_APAGADOS;
            fin_q    <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            modo_q   <= modo_d;
            anodos_q <= anodos_d;
            fin_q    <= fin_d;
        end
    end

    assign bus.seleccion  = sel_q;
    assign bus.modo       = modo_q;
    assign bus.anodos     = anodos_q;
    assign bus.fin_cuadro = fin_q;

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Directed bench for controlador_barrido_display with DIV_DIGITO=8, DEAD=2,
// FRAMES_MODO=3; cycle k is the state right after clock edge k.
module tb_controlador_barrido_display;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    controlador_barrido_display_if bus ();

    controlador_barrido_display #(
        .DIV_DIGITO  (8),
        .DEAD        (2),
        .FRAMES_MODO (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected free-running scan after eff enabled cycles since reset.
    function automatic logic [3:0] exp_an(input int eff);
        logic [3:0] uno;
        uno = 4'b0001;
        if ((eff % 8) < 2) return 4'b1111;
        return ~(uno << ((eff / 8) % 4));
    endfunction

    function automatic logic [1:0] exp_sel(input int eff);
        return 2'((eff / 8) % 4);
    endfunction

    // Hold reset for a few edges; returns in cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.habilitar   = 1'b1;
        bus.modo_auto   = 1'b1;
        bus.modo_manual = 1'b0;

        // Free run, auto mode
        do_reset();
        chk("rst_anodos", 32'(bus.anodos), 32'h0000000f);
        chk("rst_sel", 32'(bus.seleccion), 32'h0);
        chk("rst_modo", 32'(bus.modo), 32'h0);
        chk("rst_fin", 32'(bus.fin_cuadro), 32'h0);
        for (int c = 0; c < 200; c++) begin
            chk($sformatf("run_an c%0d", c), 32'(bus.anodos), 32'(exp_an(c)));
            chk($sformatf("run_sel c%0d", c), 32'(bus.seleccion), 32'(exp_sel(c)));
            chk($sformatf("run_fin c%0d", c), 32'(bus.fin_cuadro),
                32'((c > 0) && (c % 32 == 0)));
            chk($sformatf("run_modo c%0d", c), 32'(bus.modo), 32'((c / 96) % 2));
            tick();
        end

        // Manual mode: only the value at the frame-end edge matters
        bus.modo_auto   = 1'b0;
        bus.modo_manual = 1'b0;
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            bus.modo_manual = (c >= 5) && !((c >= 40) && (c <= 50)) && (c < 60);
            chk($sformatf("man_modo c%0d", c), 32'(bus.modo),
                (c < 32) ? 32'h0 : ((c < 64) ? 32'h1 : 32'h0));
            chk($sformatf("man_fin c%0d", c), 32'(bus.fin_cuadro),
                32'((c == 32) || (c == 64)));
            tick();
        end

        // Scan frozen in cycles 12..21
        bus.modo_auto   = 1'b1;
        bus.modo_manual = 1'b0;
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            int eff;
            bus.habilitar = !((c >= 11) && (c <= 20));
            eff = (c < 12) ? c : ((c <= 21) ? -1 : c - 10);
            if (eff < 0) begin
                chk($sformatf("hold_an c%0d", c), 32'(bus.anodos), 32'h0000000f);
                chk($sformatf("hold_sel c%0d", c), 32'(bus.seleccion), 32'h1);
                chk($sformatf("hold_fin c%0d", c), 32'(bus.fin_cuadro), 32'h0);
            end else begin
                chk($sformatf("hold_an c%0d", c), 32'(bus.anodos), 32'(exp_an(eff)));
                chk($sformatf("hold_sel c%0d", c), 32'(bus.seleccion), 32'(exp_sel(eff)));
                chk($sformatf("hold_fin c%0d", c), 32'(bus.fin_cuadro), 32'(c == 42));
            end
            tick();
        end
        bus.habilitar = 1'b1;

        // Reset mid-run with modo=1, habilitar low at the same time
        do_reset();
        repeat (100) tick();
        chk("pre_rst_modo", 32'(bus.modo), 32'h1);
        chk("pre_rst_an", 32'(bus.anodos), 32'h0000000e);
        reset         = 1'b1;
        bus.habilitar = 1'b0;
        tick();
        chk("mid_rst_anodos", 32'(bus.anodos), 32'h0000000f);
        chk("mid_rst_sel", 32'(bus.seleccion), 32'h0);
        chk("mid_rst_modo", 32'(bus.modo), 32'h0);
        chk("mid_rst_fin", 32'(bus.fin_cuadro), 32'h0);
        reset         = 1'b0;
        bus.habilitar = 1'b1;
        tick();
        tick();
        chk("post_rst_an", 32'(bus.anodos), 32'h0000000e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
